nav_ctrl: RTL and testbench
===========================

NAV_CTRL -- requirements
Module: nav_ctrl

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1: 1 selects ramp increment 11'h020, 0 selects 11'h010 (INC).
REQ-002 SHALL have parameter MIN_FRWRD, default 11'h0D0: starting forward speed.
REQ-003 SHALL have parameter MAX_FRWRD, default 11'h2A0: forward speed saturation value.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port strt_hdng  input  1  one-cycle request to turn to the new heading from maze_solve.
REQ-007 SHALL have port strt_mv  input  1  one-cycle request to move forward.
REQ-008 SHALL have ports stp_lft and stp_rght  input  1 each  select which side opening terminates a move.
REQ-009 SHALL have port hdng_rdy  input  1  one-cycle pulse marking a new heading sample.
REQ-010 SHALL have port at_hdng  input  1  heading error is within tolerance.
REQ-011 SHALL have ports lft_opn, rght_opn and frwrd_opn  input  1 each  wall sensor opens.
REQ-012 SHALL have port mv_cmplt  output  1  one-cycle pulse sent to maze_solve when a turn or move finishes.
REQ-013 SHALL have port moving  output  1  robot is turning or translating.
REQ-014 SHALL have port en_fusion  output  1  sensor fusion enable.
REQ-015 SHALL have port frwrd_spd  output  11  forward speed command, unsigned.

Function
REQ-016 SHALL implement states IDLE, HDNG, RAMP_UP, DEC_NORM and DEC_FAST.
REQ-017 IDLE: strt_hdng SHALL go to HDNG; otherwise strt_mv SHALL go to RAMP_UP and load frwrd_spd=MIN_FRWRD; strt_hdng wins if both are asserted in the same cycle.
REQ-018 strt_hdng and strt_mv SHALL be ignored in every state other than IDLE.
REQ-019 HDNG: at_hdng sampled high SHALL go to IDLE and pulse mv_cmplt; frwrd_spd SHALL stay 0.
REQ-020 RAMP_UP: each hdng_rdy SHALL set frwrd_spd = min(frwrd_spd+INC, MAX_FRWRD), with no overflow past MAX_FRWRD.
REQ-021 RAMP_UP exits, in priority order:
- frwrd_opn low SHALL go to DEC_FAST.
- Else a rising edge of lft_opn with stp_lft high, or of rght_opn with stp_rght high, SHALL go to DEC_NORM.
REQ-022 DEC_NORM SHALL use decrement DEC=2*INC; DEC_FAST SHALL use DEC=4*INC; frwrd_opn low in DEC_NORM SHALL go to DEC_FAST.
REQ-023 In DEC_NORM and DEC_FAST, each hdng_rdy with frwrd_spd<=DEC SHALL set frwrd_spd=0, go to IDLE and pulse mv_cmplt; otherwise it SHALL subtract DEC; frwrd_spd SHALL never underflow.
REQ-024 Rising edges SHALL be detected by flops that sample lft_opn and rght_opn every cycle; these flops SHALL reset to 1 so that an opening already present at reset does not fire.
REQ-025 mv_cmplt SHALL be registered, high exactly one cycle, in the cycle after the terminating condition is sampled.
REQ-026 moving SHALL be 1 in every state other than IDLE.
REQ-027 en_fusion SHALL be 1 when frwrd_spd > (MAX_FRWRD>>1), combinationally from the frwrd_spd register.
REQ-028 A single-cycle strt_* pulse SHALL be sufficient; no acknowledge is returned other than mv_cmplt.

Reset
REQ-029 rst SHALL take priority over all other inputs in any state, including mid-ramp or mid-decel.
REQ-030 On rst the block SHALL enter IDLE with frwrd_spd=0, mv_cmplt=0, moving=0 and en_fusion=0.
REQ-031 On rst the edge flops SHALL be set to 1.
REQ-032 A move interrupted by rst SHALL NOT produce mv_cmplt.

Structure
REQ-033 Package nav_pkg SHALL hold the state enum typedef, speed width 11 and the increment constants 11'h020 and 11'h010.
REQ-034 A single sub-module opn_edge_det SHALL be instanced once per side and output a one-cycle rise pulse.

Verification
REQ-035 The bench SHALL check: strt_mv, then 15 hdng_rdy pulses -> frwrd_spd steps 0x0D0, 0x0F0 … and saturates at 0x2A0; en_fusion rises when frwrd_spd first exceeds 0x150.
REQ-036 The bench SHALL check: at 0x2A0, stp_lft=1 and lft_opn rises -> DEC_NORM; after 10 hdng_rdy pulses frwrd_spd=0x020; the 11th pulse gives 0, then mv_cmplt for one cycle and moving=0.
REQ-037 The bench SHALL check: at 0x2A0, frwrd_opn drops -> DEC_FAST; 5 hdng_rdy pulses give 0x020; the 6th gives 0 and mv_cmplt.
REQ-038 The bench SHALL check: strt_hdng with at_hdng=0 for 20 cycles, then 1 -> moving=1 throughout, mv_cmplt once, frwrd_spd=0.
REQ-039 The bench SHALL check: strt_hdng and strt_mv in the same cycle -> HDNG; a lft_opn rise with stp_rght=1 during RAMP_UP -> no exit.
REQ-040 The bench SHALL check: rst at frwrd_spd=0x190 -> next cycle IDLE, frwrd_spd=0 and no mv_cmplt.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation controller.
package nav_pkg;

  localparam int SPD_W = 11;

  localparam logic [SPD_W-1:0] INC_FAST = 11'h020;
  localparam logic [SPD_W-1:0] INC_SLOW = 11'h010;

  // IDLE is encoded as zero so a cleared state register reads as idle.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDNG     = 3'd1,
    RAMP_UP  = 3'd2,
    DEC_NORM = 3'd3,
    DEC_FAST = 3'd4
  } nav_state_t;

endpackage

// File: rtl/opn_edge_det.sv
// Rising-edge detector for one side wall-opening sensor.
// The history flop resets to 1, so an opening that is already present at
// reset is treated as old news and does not produce a pulse.
module opn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_opn,
  output logic o_rise
);

  logic r_prev;

  // Sample the sensor every cycle so the pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_opn;
  end

  assign o_rise = i_opn & ~r_prev;

endmodule

// File: rtl/nav_ctrl.sv
// Navigation controller: turns to a heading, or ramps forward speed up,
// then decelerates when a wall opening or a blocked front is seen.
//
// Handshake: strt_hdng / strt_mv are single-cycle requests honoured only in
// IDLE (strt_hdng wins a tie); the only acknowledge is a one-cycle mv_cmplt
// pulse the cycle after the move or turn finishes. A reset-aborted move
// never completes.
//
// dbg_state exposes the FSM state register for checkers.
module nav_ctrl
  import nav_pkg::*;
#(
  parameter int               FAST_SIM  = 1,
  parameter logic [SPD_W-1:0] MIN_FRWRD = 11'h0D0,
  parameter logic [SPD_W-1:0] MAX_FRWRD = 11'h2A0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_hdng,
  input  logic             strt_mv,
  input  logic             stp_lft,
  input  logic             stp_rght,
  input  logic             hdng_rdy,
  input  logic             at_hdng,
  input  logic             lft_opn,
  input  logic             rght_opn,
  input  logic             frwrd_opn,
  output logic             mv_cmplt,
  output logic             moving,
  output logic             en_fusion,
  output logic [SPD_W-1:0] frwrd_spd,
  output logic [2:0]       dbg_state
);

  localparam logic [SPD_W-1:0] INC      = (FAST_SIM != 0) ? INC_FAST : INC_SLOW;
  localparam logic [SPD_W-1:0] STEP_NRM = INC << 1;
  localparam logic [SPD_W-1:0] STEP_FST = INC << 2;

  nav_state_t       r_state;
  logic [SPD_W-1:0] r_spd;
  logic             r_mv_cmplt;

  logic             w_lft_rise;
  logic             w_rght_rise;
  logic             w_side_stop;
  logic [SPD_W:0]   w_ramp_sum;
  logic [SPD_W-1:0] w_ramp_nxt;

  opn_edge_det u_lft_edge (
    .clk    (clk),
    .rst    (rst),
    .i_opn  (lft_opn),
    .o_rise (w_lft_rise)
  );

  opn_edge_det u_rght_edge (
    .clk    (clk),
    .rst    (rst),
    .i_opn  (rght_opn),
    .o_rise (w_rght_rise)
  );

  assign w_side_stop = (w_lft_rise & stp_lft) | (w_rght_rise & stp_rght);

  // One extra bit on the sum so saturation is decided before any wrap.
  assign w_ramp_sum = {1'b0, r_spd} + {1'b0, INC};
  assign w_ramp_nxt = (w_ramp_sum >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_ramp_sum[SPD_W-1:0];

  // Main FSM: state, speed register and the registered completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_spd      <= '0;
      r_mv_cmplt <= 1'b0;
    end else begin
      r_mv_cmplt <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (strt_hdng) begin
            r_state <= HDNG;
            r_spd   <= '0;
          end else if (strt_mv) begin
            r_state <= RAMP_UP;
            r_spd   <= MIN_FRWRD;
          end
        end
        HDNG: begin
          r_spd <= '0;
          if (at_hdng) begin
            r_state    <= IDLE;
            r_mv_cmplt <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!frwrd_opn) begin
            r_state <= DEC_FAST;
          end else if (w_side_stop) begin
            r_state <= DEC_NORM;
          end else if (hdng_rdy) begin
            r_spd <= w_ramp_nxt;
          end
        end
        DEC_NORM: begin
          if (!frwrd_opn) begin
            r_state <= DEC_FAST;
          end else if (hdng_rdy) begin
            if (r_spd <= STEP_NRM) begin
              r_spd      <= '0;
              r_state    <= IDLE;
              r_mv_cmplt <= 1'b1;
            end else begin
              r_spd <= r_spd - STEP_NRM;
            end
          end
        end
        DEC_FAST: begin
          if (hdng_rdy) begin
            if (r_spd <= STEP_FST) begin
              r_spd      <= '0;
              r_state    <= IDLE;
              r_mv_cmplt <= 1'b1;
            end else begin
              r_spd <= r_spd - STEP_FST;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_spd   <= '0;
        end
      endcase
    end
  end

  assign mv_cmplt  = r_mv_cmplt;
  assign moving    = (r_state != IDLE);
  assign en_fusion = (r_spd > (MAX_FRWRD >> 1));
  assign frwrd_spd = r_spd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nav_ctrl.sv
// Self-checking bench for nav_ctrl with default parameters.
// Expected speeds come from closed-form rules: ramp value after n samples is
// min(MIN + n*INC, MAX); decel value after k samples is max(start - k*DEC, 0).
module tb_nav_ctrl;
  import nav_pkg::*;

  localparam int MIN_S = 'h0D0;
  localparam int MAX_S = 'h2A0;
  localparam int INC_S = 'h020;
  localparam int DNRM  = 2 * INC_S;
  localparam int DFST  = 4 * INC_S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_hdng = 1'b0, strt_mv = 1'b0;
  logic        stp_lft = 1'b0, stp_rght = 1'b0;
  logic        hdng_rdy = 1'b0, at_hdng = 1'b0;
  logic        lft_opn = 1'b0, rght_opn = 1'b0, frwrd_opn = 1'b1;
  logic        mv_cmplt, moving, en_fusion;
  logic [10:0] frwrd_spd;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int spd_now;
  int mode;

  nav_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .hdng_rdy  (hdng_rdy),
    .at_hdng   (at_hdng),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .frwrd_opn (frwrd_opn),
    .mv_cmplt  (mv_cmplt),
    .moving    (moving),
    .en_fusion (en_fusion),
    .frwrd_spd (frwrd_spd),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  // checking helpers
  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input nav_state_t exp);
    chk(tag, int'(dbg_state), int'(exp));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hdng_pulse();
    hdng_rdy = 1'b1;
    tick();
    hdng_rdy = 1'b0;
  endtask

  // Random quiet cycles between heading samples: nothing may change.
  task automatic gap(input int exp_spd);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_spd", int'(frwrd_spd), exp_spd);
      chk("gap_cmplt", int'(mv_cmplt), 0);
    end
  endtask

  task automatic ramp_run(input int n, output int spd_out);
    int e;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    chk_st("ramp_enter", RAMP_UP);
    chk("ramp_min", int'(frwrd_spd), MIN_S);
    chk("ramp_moving", int'(moving), 1);
    e = MIN_S;
    for (int i = 1; i <= n; i++) begin
      hdng_pulse();
      e = (MIN_S + i * INC_S > MAX_S) ? MAX_S : MIN_S + i * INC_S;
      chk($sformatf("ramp_spd%0d", i), int'(frwrd_spd), e);
      chk($sformatf("ramp_fus%0d", i), int'(en_fusion), (e > (MAX_S >> 1)) ? 1 : 0);
      chk("ramp_cmplt", int'(mv_cmplt), 0);
      gap(e);
    end
    spd_out = e;
  endtask

  task automatic decel_run(input int spd0, input int dec, input nav_state_t st);
    int e;
    for (int k = 1; k <= 64; k++) begin
      hdng_pulse();
      e = spd0 - k * dec;
      if (e <= 0) begin
        chk($sformatf("dec_zero%0d", k), int'(frwrd_spd), 0);
        chk("dec_cmplt_hi", int'(mv_cmplt), 1);
        chk("dec_moving_lo", int'(moving), 0);
        chk_st("dec_idle", IDLE);
        tick();
        chk("dec_cmplt_lo", int'(mv_cmplt), 0);
        return;
      end
      chk($sformatf("dec_spd%0d", k), int'(frwrd_spd), e);
      chk("dec_cmplt", int'(mv_cmplt), 0);
      chk_st("dec_state", st);
      gap(e);
    end
    chk("dec_bound", 1, 0);
  endtask

  // directed sequence, then randomized moves
  initial begin
    // reset state
    rst = 1'b1;
    lft_opn = 1'b1;
    repeat (3) tick();
    chk("rst_spd", int'(frwrd_spd), 0);
    chk("rst_cmplt", int'(mv_cmplt), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_fusion", int'(en_fusion), 0);
    chk_st("rst_state", IDLE);
    rst = 1'b0;
    tick();
    lft_opn = 1'b0;
    tick();

    // ramp 15 samples to saturation, then side-opening stop
    ramp_run(15, spd_now);
    chk("sat_spd", int'(frwrd_spd), MAX_S);
    stp_lft = 1'b1;
    lft_opn = 1'b1;
    tick();
    chk_st("lft_stop", DEC_NORM);
    chk("lft_stop_spd", int'(frwrd_spd), MAX_S);
    decel_run(MAX_S, DNRM, DEC_NORM);
    lft_opn = 1'b0;
    stp_lft = 1'b0;
    tick();

    // blocked front: fast decel
    ramp_run(15, spd_now);
    frwrd_opn = 1'b0;
    tick();
    chk_st("frwrd_stop", DEC_FAST);
    decel_run(MAX_S, DFST, DEC_FAST);
    frwrd_opn = 1'b1;
    tick();

    // heading turn, 20 cycles off heading
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    chk_st("hdng_enter", HDNG);
    for (int i = 0; i < 20; i++) begin
      strt_mv = (i == 5);
      tick();
      chk("hdng_moving", int'(moving), 1);
      chk("hdng_spd", int'(frwrd_spd), 0);
      chk("hdng_cmplt", int'(mv_cmplt), 0);
    end
    strt_mv = 1'b0;
    chk_st("hdng_ignore_mv", HDNG);
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("hdng_cmplt_hi", int'(mv_cmplt), 1);
    chk("hdng_done_moving", int'(moving), 0);
    tick();
    chk("hdng_cmplt_lo", int'(mv_cmplt), 0);

    // tie: heading wins
    strt_hdng = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_hdng = 1'b0;
    strt_mv = 1'b0;
    chk_st("tie_hdng", HDNG);
    chk("tie_spd", int'(frwrd_spd), 0);
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("tie_cmplt", int'(mv_cmplt), 1);

    // wrong-side opening does not stop; strt_hdng ignored mid-move
    ramp_run(2, spd_now);
    stp_rght = 1'b1;
    lft_opn = 1'b1;
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    chk_st("wrong_side", RAMP_UP);
    tick();
    chk_st("wrong_side2", RAMP_UP);
    lft_opn = 1'b0;
    rght_opn = 1'b1;
    tick();
    chk_st("rght_stop", DEC_NORM);
    decel_run(spd_now, DNRM, DEC_NORM);
    rght_opn = 1'b0;
    stp_rght = 1'b0;
    tick();

    // reset mid-ramp at 0x190
    ramp_run(6, spd_now);
    chk("pre_rst_spd", int'(frwrd_spd), 'h190);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_st("mid_rst_state", IDLE);
    chk("mid_rst_spd", int'(frwrd_spd), 0);
    chk("mid_rst_cmplt", int'(mv_cmplt), 0);
    for (int i = 0; i < 3; i++) begin
      hdng_pulse();
      chk("post_rst_cmplt", int'(mv_cmplt), 0);
      chk("post_rst_moving", int'(moving), 0);
    end

    // randomized moves
    for (int r = 0; r < 8; r++) begin
      ramp_run($urandom_range(0, 17), spd_now);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        frwrd_opn = 1'b0;
        tick();
        chk_st("rnd_fast", DEC_FAST);
        decel_run(spd_now, DFST, DEC_FAST);
        frwrd_opn = 1'b1;
      end else if (mode == 1) begin
        stp_lft = 1'b1;
        lft_opn = 1'b1;
        tick();
        chk_st("rnd_lft", DEC_NORM);
        decel_run(spd_now, DNRM, DEC_NORM);
        lft_opn = 1'b0;
        stp_lft = 1'b0;
      end else begin
        stp_rght = 1'b1;
        rght_opn = 1'b1;
        tick();
        chk_st("rnd_rght", DEC_NORM);
        decel_run(spd_now, DNRM, DEC_NORM);
        rght_opn = 1'b0;
        stp_rght = 1'b0;
      end
      tick();
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
